// File: rtl/ch_sweep_sar_ctl.sv
// Delay-line sweep controller: per delay code, finds the comparator threshold
// crossing by MSB-first successive approximation with majority-voted strobes.
module ch_sweep_sar_ctl #(
  parameter int unsigned TH_W    = 16,
  parameter int unsigned DC_W    = 10,
  parameter int unsigned NS_W    = 4,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            run_i,
  input  logic [DC_W-1:0] d_start_i,
  input  logic [DC_W-1:0] d_stop_i,
  input  logic [DC_W-1:0] d_step_i,
  input  logic [NS_W-1:0] n_samp_i,
  output logic            stb_req_o,
  input  logic            stb_valid_i,
  input  logic            cmp_out_i,
  output logic [TH_W-1:0] threshold_o,
  output logic            threshold_wre_o,
  input  logic            threshold_rdy_i,
  output logic [DC_W-1:0] d_code_o,
  output logic            pt_valid_o,
  input  logic            pt_ready_i,
  output logic [DC_W-1:0] pt_d_code_o,
  output logic [TH_W-1:0] pt_threshold_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o
);

  localparam int unsigned B_W = (TH_W > 1) ? $clog2(TH_W) : 1;
  localparam int unsigned T_W = $clog2(TMO_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_SET_TH       = 4'd1,
    S_WAIT_RDY_NEG = 4'd2,
    S_WAIT_TH      = 4'd3,
    S_REQ_STB      = 4'd4,
    S_WAIT_STB     = 4'd5,
    S_DECIDE       = 4'd6,
    S_EMIT         = 4'd7,
    S_DONE         = 4'd8
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DC_W-1:0] r_d_stop, w_d_stop_nxt;
  logic [DC_W-1:0] r_step, w_step_nxt;
  logic [NS_W-1:0] r_nsamp, w_nsamp_nxt;
  logic [B_W-1:0]  r_bit, w_bit_nxt;
  logic [TH_W-1:0] r_result, w_result_nxt;
  logic [NS_W-1:0] r_ones, w_ones_nxt;
  logic [NS_W-1:0] r_cnt, w_cnt_nxt;
  logic [T_W-1:0]  r_tmo, w_tmo_nxt;
  logic [TH_W-1:0] r_thr, w_thr_nxt;
  logic            r_wre, w_wre_nxt;
  logic            r_stb_req, w_stb_req_nxt;
  logic [DC_W-1:0] r_d_code, w_d_code_nxt;
  logic            r_pt_valid, w_pt_valid_nxt;
  logic [DC_W-1:0] r_pt_d_code, w_pt_d_code_nxt;
  logic [TH_W-1:0] r_pt_thr, w_pt_thr_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic [TH_W-1:0] w_trial;
  logic [DC_W:0]   w_sum;
  logic            w_tmo_hit;
  logic            w_keep;
  logic [NS_W-1:0] w_cnt_inc;

  // Trial code for the bit under test, and the next delay code with carry out
  assign w_trial   = r_result | (TH_W'(1) << r_bit);
  assign w_sum     = {1'b0, r_d_code} + {1'b0, r_step};
  assign w_tmo_hit = (r_tmo == T_W'(TMO_CYC - 1));
  assign w_keep    = ({r_ones, 1'b0} > {1'b0, r_nsamp});
  assign w_cnt_inc = r_cnt + NS_W'(1);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= S_IDLE;
      r_d_stop    <= '0;
      r_step      <= '0;
      r_nsamp     <= '0;
      r_bit       <= '0;
      r_result    <= '0;
      r_ones      <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_thr       <= '0;
      r_wre       <= 1'b0;
      r_stb_req   <= 1'b0;
      r_d_code    <= '0;
      r_pt_valid  <= 1'b0;
      r_pt_d_code <= '0;
      r_pt_thr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_d_stop    <= w_d_stop_nxt;
      r_step      <= w_step_nxt;
      r_nsamp     <= w_nsamp_nxt;
      r_bit       <= w_bit_nxt;
      r_result    <= w_result_nxt;
      r_ones      <= w_ones_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_thr       <= w_thr_nxt;
      r_wre       <= w_wre_nxt;
      r_stb_req   <= w_stb_req_nxt;
      r_d_code    <= w_d_code_nxt;
      r_pt_valid  <= w_pt_valid_nxt;
      r_pt_d_code <= w_pt_d_code_nxt;
      r_pt_thr    <= w_pt_thr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_d_stop_nxt    = r_d_stop;
    w_step_nxt      = r_step;
    w_nsamp_nxt     = r_nsamp;
    w_bit_nxt       = r_bit;
    w_result_nxt    = r_result;
    w_ones_nxt      = r_ones;
    w_cnt_nxt       = r_cnt;
    w_tmo_nxt       = r_tmo;
    w_thr_nxt       = r_thr;
    w_wre_nxt       = 1'b0;
    w_stb_req_nxt   = 1'b0;
    w_d_code_nxt    = r_d_code;
    w_pt_valid_nxt  = r_pt_valid;
    w_pt_d_code_nxt = r_pt_d_code;
    w_pt_thr_nxt    = r_pt_thr;
    w_done_nxt      = r_done;
    w_timeout_nxt   = r_timeout;
    w_busy_nxt      = 1'b0;

    if (!run_i) begin
      // Abort: pulses and any pending point are dropped, codes hold
      w_state_nxt    = S_IDLE;
      w_pt_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_d_stop_nxt  = d_stop_i;
          w_step_nxt    = (d_step_i == '0) ? DC_W'(1) : d_step_i;
          w_nsamp_nxt   = (n_samp_i == '0) ? NS_W'(1) : n_samp_i;
          w_d_code_nxt  = d_start_i;
          w_bit_nxt     = B_W'(TH_W - 1);
          w_result_nxt  = '0;
          w_ones_nxt    = '0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b0;
          w_done_nxt    = 1'b0;
          w_state_nxt   = S_SET_TH;
        end
        S_SET_TH: begin
          w_thr_nxt   = w_trial;
          w_wre_nxt   = 1'b1;
          w_state_nxt = S_WAIT_RDY_NEG;
        end
        S_WAIT_RDY_NEG: begin
          w_tmo_nxt   = '0;
          w_state_nxt = S_WAIT_TH;
        end
        S_WAIT_TH: begin
          if (threshold_rdy_i) begin
            w_stb_req_nxt = 1'b1;
            w_state_nxt   = S_REQ_STB;
          end else if (w_tmo_hit) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_tmo_nxt = r_tmo + T_W'(1);
          end
        end
        S_REQ_STB: begin
          w_tmo_nxt   = '0;
          w_state_nxt = S_WAIT_STB;
        end
        S_WAIT_STB: begin
          // A strobe landing on the timeout cycle still counts
          if (stb_valid_i) begin
            w_ones_nxt = r_ones + NS_W'(cmp_out_i);
            w_cnt_nxt  = w_cnt_inc;
            if (w_cnt_inc == r_nsamp) begin
              w_state_nxt = S_DECIDE;
            end else begin
              w_stb_req_nxt = 1'b1;
              w_state_nxt   = S_REQ_STB;
            end
          end else if (w_tmo_hit) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_tmo_nxt = r_tmo + T_W'(1);
          end
        end
        S_DECIDE: begin
          w_result_nxt = w_keep ? w_trial : r_result;
          w_ones_nxt   = '0;
          w_cnt_nxt    = '0;
          if (r_bit != '0) begin
            w_bit_nxt   = r_bit - B_W'(1);
            w_state_nxt = S_SET_TH;
          end else begin
            w_pt_valid_nxt  = 1'b1;
            w_pt_d_code_nxt = r_d_code;
            w_pt_thr_nxt    = w_keep ? w_trial : r_result;
            w_state_nxt     = S_EMIT;
          end
        end
        S_EMIT: begin
          if (pt_ready_i) begin
            w_pt_valid_nxt = 1'b0;
            if (w_sum[DC_W] || (w_sum[DC_W-1:0] > r_d_stop)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_d_code_nxt = w_sum[DC_W-1:0];
              w_result_nxt = '0;
              w_bit_nxt    = B_W'(TH_W - 1);
              w_state_nxt  = S_SET_TH;
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
  end

  assign stb_req_o       = r_stb_req;
  assign threshold_o     = r_thr;
  assign threshold_wre_o = r_wre;
  assign d_code_o        = r_d_code;
  assign pt_valid_o      = r_pt_valid;
  assign pt_d_code_o     = r_pt_d_code;
  assign pt_threshold_o  = r_pt_thr;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign timeout_o       = r_timeout;

endmodule
